i2c_slave_ctrl: RTL and testbench

//  I2C slave protocol engine sitting directly upstream of the 128x8 I2C RAM. It

---
 rtl/i2c_slave_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol engine in front of a 128x8 RAM.
// Oversamples SCL/SDA, ACKs its address, and bridges bytes to RAM strobes.
module i2c_slave_ctrl #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en_out,
  output logic       rd_en_out,
  output logic [6:0] addr_out,
  output logic [7:0] data_out,
  input  logic [7:0] data_in,
  output logic       busy_out
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic scl_rise, scl_fall, start, stop;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop     = scl_s & scl_d & ~sda_d & sda_s;

  state_t     state_q, state_n;
  logic [3:0] cnt_q, cnt_n;
  logic [7:0] shreg_q, shreg_n;
  logic [6:0] ptr_q, ptr_n;
  logic       rw_q, rw_n;
  logic       oe_n, wr_n, rd_n, busy_n;
  logic [6:0] addr_n;
  logic [7:0] data_n;
  logic [7:0] byte_v;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe    <= 1'b0;
      wr_en_out <= 1'b0;
      rd_en_out <= 1'b0;
      addr_out  <= '0;
      data_out  <= '0;
      busy_out  <= 1'b0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      shreg_q   <= shreg_n;
      ptr_q     <= ptr_n;
      rw_q      <= rw_n;
      sda_oe    <= oe_n;
      wr_en_out <= wr_n;
      rd_en_out <= rd_n;
      addr_out  <= addr_n;
      data_out  <= data_n;
      busy_out  <= busy_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    shreg_n = shreg_q;
    ptr_n   = ptr_q;
    rw_n    = rw_q;
    oe_n    = sda_oe;
    wr_n    = 1'b0;
    rd_n    = 1'b0;
    addr_n  = addr_out;
    data_n  = data_out;
    busy_n  = busy_out;
    byte_v  = {shreg_q[6:0], sda_s};

    // post-write increment lands the cycle after the strobe
    if (wr_en_out) ptr_n = ptr_q + 7'd1;

    if (stop) begin
      state_n = IDLE;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (start) begin
      state_n = DEV_ADDR;
      cnt_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: ;
        DEV_ADDR, REG_ADDR, WR_DATA: begin
          if (scl_rise) begin
            shreg_n = byte_v;
            cnt_n   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              unique case (state_q)
                DEV_ADDR: begin
                  rw_n    = byte_v[0];
                  state_n = (byte_v[7:1] == SLAVE_ADDR)
                            ? DEV_ACK : IDLE;
                end
                REG_ADDR: begin
                  ptr_n   = byte_v[6:0];
                  state_n = REG_ACK;
                end
                default: begin
                  wr_n    = 1'b1;
                  addr_n  = ptr_q;
                  data_n  = byte_v;
                  state_n = WR_ACK;
                end
              endcase
            end
          end
        end
        DEV_ACK, REG_ACK, WR_ACK: begin
          // first fall pulls SDA, second fall releases it
          if (scl_fall) begin
            if (!sda_oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n  = 1'b0;
              cnt_n = '0;
              if (state_q != DEV_ACK) begin
                state_n = WR_DATA;
              end else if (!rw_q) begin
                state_n = REG_ADDR;
              end else begin
                state_n = RD_LOAD;
                rd_n    = 1'b1;
                addr_n  = ptr_q;
              end
            end
          end
        end
        RD_LOAD: begin
          if (!rd_en_out) begin
            shreg_n = data_in;
            oe_n    = ~data_in[7];
            ptr_n   = ptr_q + 7'd1;
            cnt_n   = 4'd1;
            state_n = RD_DATA;
          end
        end
        RD_DATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_n    = 1'b0;
              state_n = RD_MACK;
            end else begin
              shreg_n = {shreg_q[6:0], 1'b0};
              oe_n    = ~shreg_q[6];
              cnt_n   = cnt_q + 4'd1;
            end
          end
        end
        RD_MACK: begin
          if (scl_rise) begin
            shreg_n = {shreg_q[7:1], sda_s};
          end else if (scl_fall) begin
            if (!shreg_q[0]) begin
              state_n = RD_LOAD;
              rd_n    = 1'b1;
              addr_n  = ptr_q;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Directed bench for i2c_slave_ctrl: bit-banged master,
// behavioural 128x8 RAM, strobe logging and hand-computed expectations.
module tb_i2c_slave_ctrl;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_pad;
  logic       sda_oe, wr_en, rd_en, busy;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;

  logic [7:0]  mem [128];
  logic [14:0] wr_log [$];
  logic [6:0]  rd_log [$];
  logic        oe_seen;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign sda_pad = sda_m & ~sda_oe;

  i2c_slave_ctrl dut (
    .clock_in  (clk),
    .reset_in  (rst),
    .scl_in    (scl),
    .sda_in    (sda_pad),
    .sda_oe    (sda_oe),
    .wr_en_out (wr_en),
    .rd_en_out (rd_en),
    .addr_out  (addr),
    .data_out  (wdata),
    .data_in   (rdata),
    .busy_out  (busy)
  );

  always @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (rd_en) rdata <= mem[addr];
  end

  always @(negedge clk) begin
    if (wr_en) wr_log.push_back({addr, wdata});
    if (rd_en) rd_log.push_back(addr);
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic qw();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw();
    scl = 1'b1;   qw();
    sda_m = 1'b0; qw();
    scl = 1'b0;   qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw();
    scl = 1'b1;   qw();
    sda_m = 1'b1; qw();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b;  qw();
    scl = 1'b1; qw(); qw();
    scl = 1'b0; qw();
  endtask

  task automatic send_byte(input logic [7:0] b,
                           output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    sda_m = 1'b1; qw();
    scl = 1'b1;   qw();
    ack = ~sda_pad;
    qw();
    scl = 1'b0;   qw();
  endtask

  task automatic read_byte(input logic nack,
                           output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; qw();
      scl = 1'b1;   qw();
      b[i] = sda_pad;
      qw();
      scl = 1'b0;   qw();
    end
    put_bit(nack);
    sda_m = 1'b1;
  endtask

  logic       ack;
  logic [7:0] rb;
  int         acks;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    rdata = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_oe",   sda_oe, 0);
    chk("rst_wr",   wr_en,  0);
    chk("rst_rd",   rd_en,  0);
    chk("rst_addr", addr,   0);
    chk("rst_data", wdata,  0);
    chk("rst_busy", busy,   0);
    @(posedge clk);
    rst = 1'b0;
    qw();

    // 1: two-byte write from 0x10
    wr_log.delete();
    acks = 0;
    i2c_start();
    chk("t1_busy", busy, 1);
    send_byte(8'hA0, ack); acks += int'(ack);
    send_byte(8'h10, ack); acks += int'(ack);
    send_byte(8'hA5, ack); acks += int'(ack);
    send_byte(8'h3C, ack); acks += int'(ack);
    i2c_stop(); qw();
    chk("t1_acks", acks, 4);
    chk("t1_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t1_wr0", wr_log[0], {7'h10, 8'hA5});
      chk("t1_wr1", wr_log[1], {7'h11, 8'h3C});
    end
    chk("t1_hold_a", addr,  7'h11);
    chk("t1_hold_d", wdata, 8'h3C);
    chk("t1_busy0",  busy,  0);

    // 2: set pointer, repeated start, read back two bytes
    wr_log.delete();
    rd_log.delete();
    acks = 0;
    i2c_start();
    send_byte(8'hA0, ack); acks += int'(ack);
    send_byte(8'h10, ack); acks += int'(ack);
    i2c_start();
    send_byte(8'hA1, ack); acks += int'(ack);
    chk("t2_acks", acks, 3);
    read_byte(1'b0, rb);
    chk("t2_rd0", rb, 8'hA5);
    read_byte(1'b1, rb);
    chk("t2_rd1", rb, 8'h3C);
    qw();
    chk("t2_oe_nack", sda_oe, 0);
    chk("t2_busy1", busy, 1);
    i2c_stop(); qw();
    chk("t2_busy0", busy, 0);
    chk("t2_nrd", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      chk("t2_ra0", rd_log[0], 7'h10);
      chk("t2_ra1", rd_log[1], 7'h11);
    end
    chk("t2_nwr", wr_log.size(), 0);

    // 3: foreign address is ignored
    wr_log.delete();
    rd_log.delete();
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'hA2, ack);
    chk("t3_nack_a", ack, 0);
    send_byte(8'h55, ack);
    i2c_stop(); qw();
    chk("t3_oe", oe_seen, 0);
    chk("t3_nwr", wr_log.size(), 0);
    chk("t3_nrd", rd_log.size(), 0);

    // 4: pointer wraps 0x7F -> 0x00
    wr_log.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h7F, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    i2c_stop(); qw();
    chk("t4_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("t4_wr0", wr_log[0], {7'h7F, 8'h11});
      chk("t4_wr1", wr_log[1], {7'h00, 8'h22});
    end

    // 5: partial byte aborted by STOP
    wr_log.delete();
    rd_log.delete();
    i2c_start();
    send_byte(8'hA0, ack);
    send_byte(8'h20, ack);
    put_bit(1'b1); put_bit(1'b0);
    put_bit(1'b1); put_bit(1'b1);
    i2c_stop(); qw();
    chk("t5_nwr", wr_log.size(), 0);
    chk("t5_busy", busy, 0);
    chk("t5_oe", sda_oe, 0);
    i2c_start();
    send_byte(8'hA1, ack);
    read_byte(1'b1, rb);
    i2c_stop(); qw();
    chk("t5_nrd", rd_log.size(), 1);
    if (rd_log.size() == 1)
      chk("t5_ptr", rd_log[0], 7'h20);

    // 6: reset while slave ACKs a read address
    rd_log.delete();
    i2c_start();
    for (int i = 7; i >= 0; i--) put_bit(8'hA1 >> i);
    sda_m = 1'b1; qw();
    chk("t6_ack_on", sda_oe, 1);
    @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t6_oe",   sda_oe, 0);
    chk("t6_busy", busy,   0);
    chk("t6_addr", addr,   0);
    chk("t6_data", wdata,  0);
    chk("t6_wr",   wr_en,  0);
    chk("t6_rd",   rd_en,  0);
    @(posedge clk);
    rst = 1'b0;
    scl = 1'b1; qw();
    scl = 1'b0; qw(); qw();
    chk("t6_idle_oe", sda_oe, 0);
    chk("t6_nrd", rd_log.size(), 0);
    i2c_stop(); qw();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
